// File: rtl/zr_bus_demux.sv
// zr_bus_demux
//   Single-initiator to N_TARGETS-target bus demultiplexer. The request
//   channel is decoded from addr_i and routed combinationally to one target.
//   Responses come back strictly in order: a new target is only selected once
//   every transfer outstanding at the previous target has returned.
//
// Parameters
//   N_TARGETS       number of target ports (1..8)
//   MAX_OUTSTANDING granted requests that may await rvalid (1..7)
//   ADDR_BASE/MASK  per-target base address and offset mask, index 0 lowest
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_i/gnt_o                   initiator request handshake
//   addr_i, we_i, be_i, wdata_i   initiator request payload
//   rvalid_o, rdata_o, err_o      initiator response (rdata_o is 0 when idle)
//   t_req_o/t_gnt_i               per-target request handshake
//   t_addr_o, t_we_o, t_be_o,
//   t_wdata_o                     request payload broadcast to all targets
//   t_rvalid_i, t_rdata_i,
//   t_err_i                       per-target responses
//
// Build option
//   ZR_BUS_DEMUX_DECERR_EN  unmapped addresses are answered by an internal
//                           responder (pseudo-target N_TARGETS): granted at
//                           once, rvalid_o with err_o=1 and rdata_o=0 one cycle
//                           later. Undefined: unmapped requests are never
//                           granted.
module zr_bus_demux #(
  parameter int unsigned                N_TARGETS       = 3,
  parameter int unsigned                MAX_OUTSTANDING = 2,
  parameter logic [N_TARGETS-1:0][31:0] ADDR_BASE       = {32'h0000_4000, 32'h0000_0000, 32'h8000_0000},
  parameter logic [N_TARGETS-1:0][31:0] ADDR_MASK       = {32'h0000_0fff, 32'h0000_3fff, 32'h0000_3fff}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             wdata_i,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic [N_TARGETS-1:0]    t_req_o,
  input  logic [N_TARGETS-1:0]    t_gnt_i,
  output logic [31:0]             t_addr_o,
  output logic                    t_we_o,
  output logic [3:0]              t_be_o,
  output logic [31:0]             t_wdata_o,
  input  logic [N_TARGETS-1:0]    t_rvalid_i,
  input  logic [N_TARGETS*32-1:0] t_rdata_i,
  input  logic [N_TARGETS-1:0]    t_err_i
);

`ifdef ZR_BUS_DEMUX_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  // Target index width includes the pseudo-target code N_TARGETS.
  localparam int unsigned TW = $clog2(N_TARGETS + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [TW-1:0] r_cur_tgt;
  logic [CW-1:0] r_cnt;
  logic          r_decerr_pend;

  logic          w_mapped;
  logic [TW-1:0] w_dec_tgt;
  logic          w_tgt_gnt;
  logic          w_sel_rvalid;
  logic          w_sel_err;
  logic [31:0]   w_sel_rdata;
  logic          w_drain_last;
  logic          w_stall;
  logic          w_go;

  assign t_addr_o  = addr_i;
  assign t_we_o    = we_i;
  assign t_be_o    = be_i;
  assign t_wdata_o = wdata_i;

  // Address decode, lowest matching index wins.
  always_comb begin
    w_mapped  = 1'b0;
    w_dec_tgt = TW'(N_TARGETS);
    for (int unsigned k = 0; k < N_TARGETS; k++) begin
      if (!w_mapped && ((addr_i & ~ADDR_MASK[k]) == (ADDR_BASE[k] & ~ADDR_MASK[k]))) begin
        w_mapped  = 1'b1;
        w_dec_tgt = TW'(k);
      end
    end
  end

  // Response mux from the target owning the outstanding transfers.
  always_comb begin
    w_sel_rvalid = DECERR_EN && (r_cur_tgt == TW'(N_TARGETS)) && r_decerr_pend;
    w_sel_err    = DECERR_EN && (r_cur_tgt == TW'(N_TARGETS));
    w_sel_rdata  = '0;
    for (int unsigned k = 0; k < N_TARGETS; k++) begin
      if (r_cur_tgt == TW'(k)) begin
        w_sel_rvalid = t_rvalid_i[k];
        w_sel_err    = t_err_i[k];
        w_sel_rdata  = t_rdata_i[k*32 +: 32];
      end
    end
  end

  assign rvalid_o = (r_cnt != '0) && w_sel_rvalid;
  assign rdata_o  = rvalid_o ? w_sel_rdata : '0;
  assign err_o    = rvalid_o && w_sel_err;

  // A response retiring in this cycle frees its slot (and, if it is the last
  // one, releases the target lock) for a request in the same cycle, so a
  // stalled request is granted in the very cycle the blocking rvalid arrives.
  assign w_drain_last = rvalid_o && (r_cnt == CW'(1));
  assign w_stall = ((r_cnt == CW'(MAX_OUTSTANDING)) && !rvalid_o) ||
                   ((r_cnt != '0) && (w_dec_tgt != r_cur_tgt) && !w_drain_last);
  assign w_go    = req_i && !w_stall;

  always_comb begin
    t_req_o   = '0;
    w_tgt_gnt = 1'b0;
    for (int unsigned k = 0; k < N_TARGETS; k++) begin
      if (w_mapped && (w_dec_tgt == TW'(k))) begin
        t_req_o[k] = w_go;
        w_tgt_gnt  = t_gnt_i[k];
      end
    end
  end

  assign gnt_o = w_go && (w_mapped ? w_tgt_gnt : DECERR_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_cur_tgt     <= '0;
      r_decerr_pend <= 1'b0;
    end else begin
      if (gnt_o) begin
        r_cur_tgt <= w_dec_tgt;
      end
      r_decerr_pend <= DECERR_EN && gnt_o && !w_mapped;
      if (gnt_o && !rvalid_o) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!gnt_o && rvalid_o) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_zr_bus_demux.sv
module tb_zr_bus_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [2:0]  t_req_o;
  logic [2:0]  t_gnt_i;
  logic [31:0] t_addr_o;
  logic        t_we_o;
  logic [3:0]  t_be_o;
  logic [31:0] t_wdata_o;
  logic [2:0]  t_rvalid_i;
  logic [95:0] t_rdata_i;
  logic [2:0]  t_err_i;

  logic [2:0]  gnt_en;
  logic [2:0]  rv_en;

  int passed = 0;
  int total  = 0;

  logic [32:0] sb [$];        // expected {err, rdata}
  logic [31:0] tq [3][$];     // per-target accepted addresses

  localparam logic [31:0] TAG [3] = '{32'h0A00_0000, 32'h0B00_0000, 32'h0C00_0000};

  always #5 clk = ~clk;

  zr_bus_demux #(.N_TARGETS(3), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .t_req_o(t_req_o), .t_gnt_i(t_gnt_i), .t_addr_o(t_addr_o), .t_we_o(t_we_o),
    .t_be_o(t_be_o), .t_wdata_o(t_wdata_o), .t_rvalid_i(t_rvalid_i),
    .t_rdata_i(t_rdata_i), .t_err_i(t_err_i)
  );

  assign t_gnt_i = t_req_o & gnt_en;

  // Target models: response one cycle after grant (while rv_en), data = addr ^ TAG,
  // err = addr[12]. Idle targets drive junk data and err=1.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (t_rvalid_i[k] === 1'b1 && tq[k].size() != 0) void'(tq[k].pop_front());
      if (t_req_o[k] === 1'b1 && t_gnt_i[k] === 1'b1) tq[k].push_back(t_addr_o);
      if (tq[k].size() != 0 && rv_en[k]) begin
        t_rvalid_i[k]        <= 1'b1;
        t_rdata_i[k*32 +: 32] <= tq[k][0] ^ TAG[k];
        t_err_i[k]           <= tq[k][0][12];
      end else begin
        t_rvalid_i[k]        <= 1'b0;
        t_rdata_i[k*32 +: 32] <= 32'hDEAD_BEEF;
        t_err_i[k]           <= 1'b1;
      end
    end
  end

  // Monitor: every rvalid_o must match the oldest expected response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rvalid_o === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rvalid: rvalid_o=1 rdata=%h, required rvalid_o=0", rdata_o);
      end else begin
        e = sb.pop_front();
        if ({err_o, rdata_o} === e) passed++;
        else $display("FAIL resp: got err=%b rdata=%h, required err=%b rdata=%h",
                      err_o, rdata_o, e[32], e[31:0]);
      end
    end else begin
      total++;
      if (rdata_o === 32'h0 && (rst_n === 1'b1 || err_o === 1'b0)) passed++;
      else $display("FAIL idle_out: rdata_o=%h err_o=%b, required rdata_o=0", rdata_o, err_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // Raise a request and wait at most maxw extra cycles for gnt_o; on grant the
  // expected response is queued. Returns one cycle after the grant, req_i still high.
  task automatic issue(input string nm, input logic [31:0] a, input logic w,
                       input logic [31:0] ed, input logic ee, input int unsigned maxw);
    int unsigned n = 0;
    req_i = 1'b1; addr_i = a; we_i = w; wdata_i = ~a; be_i = 4'hF;
    @(negedge clk);
    while (gnt_o !== 1'b1 && n < maxw) begin
      tick();
      @(negedge clk);
      n++;
    end
    total++;
    if (gnt_o === 1'b1) begin
      passed++;
      sb.push_back({ee, ed});
    end else begin
      $display("FAIL %s: gnt_o=%b after %0d cycles, required 1", nm, gnt_o, n);
    end
    tick();
  endtask

  localparam logic [31:0] DEC_A [6] = '{32'h8000_0000, 32'h8000_3FFC, 32'h0000_0000,
                                        32'h0000_3FFC, 32'h0000_4000, 32'h0000_4FFC};
  localparam logic [2:0]  DEC_T [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

  initial begin
    req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    gnt_en = '0; rv_en = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("rst_err",    {31'h0, err_o},    32'h0);
    chk("rst_rdata",  rdata_o,           32'h0);
    chk("rst_req",    {28'h0, gnt_o, t_req_o}, 32'h0);
    tick(); tick();

    // Back-to-back reads starting in the first cycle out of reset
    rst_n = 1'b1; gnt_en = 3'b111; rv_en = 3'b111;
    issue("b2b_gnt0", 32'h8000_0010, 1'b0, 32'h8A00_0010, 1'b0, 0);
    issue("b2b_gnt1", 32'h8000_0014, 1'b0, 32'h8A00_0014, 1'b0, 0);
    req_i = 1'b0;
    tick(); tick(); tick();

    // Decode table (no target grants, so nothing is accepted)
    gnt_en = '0;
    for (int i = 0; i < 6; i++) begin
      req_i = 1'b1; addr_i = DEC_A[i]; we_i = i[0]; be_i = 4'(i + 3); wdata_i = ~DEC_A[i];
      @(negedge clk);
      chk($sformatf("decode_%0d", i), {28'h0, gnt_o, t_req_o}, {29'h0, DEC_T[i]});
      chk($sformatf("bcast_%0d", i), t_addr_o ^ t_wdata_o, 32'hFFFF_FFFF);
      chk($sformatf("bcast_ctl_%0d", i), {27'h0, t_we_o, t_be_o}, {27'h0, i[0], 4'(i + 3)});
      req_i = 1'b0;
      tick();
    end

    // Outstanding limit: third request waits for first rvalid, granted that cycle
    gnt_en = 3'b111; rv_en = 3'b000;
    issue("lim_gnt0", 32'h8000_0020, 1'b0, 32'h8A00_0020, 1'b0, 0);
    issue("lim_gnt1", 32'h8000_0024, 1'b0, 32'h8A00_0024, 1'b0, 0);
    addr_i = 32'h8000_0028; wdata_i = ~addr_i;
    @(negedge clk);
    chk("lim_stall0", {28'h0, gnt_o, t_req_o}, 32'h0);
    tick();
    rv_en[0] = 1'b1;
    @(negedge clk);
    chk("lim_stall1", {28'h0, gnt_o, t_req_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("lim_release", {27'h0, rvalid_o, gnt_o, t_req_o}, 32'h19);
    if (gnt_o === 1'b1) sb.push_back({1'b0, 32'h8A00_0028});
    tick();
    req_i = 1'b0;
    tick(); tick(); tick();

    // Target switch waits for the previous target to drain
    rv_en = 3'b100;
    issue("sw_gnt0", 32'h8000_0000, 1'b0, 32'h8A00_0000, 1'b0, 0);
    addr_i = 32'h0000_4000; we_i = 1'b1; wdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("sw_stall0", {28'h0, gnt_o, t_req_o}, 32'h0);
    tick();
    rv_en[0] = 1'b1;
    @(negedge clk);
    chk("sw_stall1", {28'h0, gnt_o, t_req_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("sw_release", {27'h0, rvalid_o, gnt_o, t_req_o}, 32'h1C);
    if (gnt_o === 1'b1) sb.push_back({1'b0, 32'h0C00_4000});
    tick();
    req_i = 1'b0; we_i = 1'b0;
    tick(); tick(); tick();

    // Target error passthrough
    rv_en = 3'b111;
    issue("err_gnt", 32'h0000_1000, 1'b0, 32'h0B00_1000, 1'b1, 0);
    req_i = 1'b0;
    tick(); tick();

    // Unmapped addresses
`ifdef ZR_BUS_DEMUX_DECERR_EN
    issue("decerr_gnt0", 32'h2000_0000, 1'b0, 32'h0, 1'b1, 0);
    req_i = 1'b0;
    @(negedge clk);
    chk("decerr_rsp0", {30'h0, rvalid_o, err_o}, 32'h3);
    tick();
    issue("decerr_gnt1", 32'h0000_5000, 1'b1, 32'h0, 1'b1, 0);
    req_i = 1'b0;
    @(negedge clk);
    chk("decerr_rsp1", {30'h0, rvalid_o, err_o}, 32'h3);
    tick(); tick();
`else
    req_i = 1'b1; addr_i = 32'h2000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("unmapped_%0d", i), {28'h0, gnt_o, t_req_o}, 32'h0);
      tick();
    end
    req_i = 1'b0;
    tick();
`endif

    // Reset with two transfers outstanding; late rvalids must be ignored
    rv_en = 3'b000;
    issue("rst_gnt0", 32'h8000_0030, 1'b0, 32'h0, 1'b0, 0);
    issue("rst_gnt1", 32'h8000_0034, 1'b0, 32'h0, 1'b0, 0);
    req_i = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst2_out", {28'h0, rvalid_o, err_o, 2'b00} | (rdata_o != 0 ? 32'h1 : 32'h0), 32'h0);
    tick();
    rst_n = 1'b1; rv_en[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("stray0", {31'h0, rvalid_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("stray1", {31'h0, rvalid_o}, 32'h0);
    tick(); tick();
    issue("post_rst_gnt", 32'h8000_0040, 1'b0, 32'h8A00_0040, 1'b0, 0);
    req_i = 1'b0;
    tick(); tick(); tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zr_bus_demux.md
ZR_BUS_DEMUX -- requirements
Module: zr_bus_demux

Interface
REQ-001 SHALL have parameter N_TARGETS, default 3: number of target ports, range 1..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum granted requests awaiting rvalid, range 1..7.
REQ-003 SHALL have parameter ADDR_BASE [N_TARGETS-1:0][31:0], default {32'h0000_4000, 32'h0000_0000, 32'h8000_0000}: target base addresses, index 0 lowest.
REQ-004 SHALL have parameter ADDR_MASK [N_TARGETS-1:0][31:0], default {32'h0000_0fff, 32'h0000_3fff, 32'h0000_3fff}: per-target offset masks.
REQ-005 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have initiator ports: req_i in 1; gnt_o out 1; addr_i in 32; we_i in 1; be_i in 4; wdata_i in 32; rvalid_o out 1; rdata_o out 32; err_o out 1.
REQ-007 SHALL have target ports: t_req_o out N_TARGETS; t_gnt_i in N_TARGETS; t_addr_o out 32; t_we_o out 1; t_be_o out 4; t_wdata_o out 32; t_rvalid_i in N_TARGETS; t_rdata_i in N_TARGETS*32; t_err_i in N_TARGETS.
REQ-008 SHALL operate on one clock, clk; reset rst_n SHALL be asynchronous, active-low.

Function
REQ-009 SHALL decode hit[k] = ((addr_i & ~ADDR_MASK[k]) == (ADDR_BASE[k] & ~ADDR_MASK[k])); on multiple hits, the lowest index wins; no hit means unmapped.
REQ-010 SHALL broadcast addr_i, we_i, be_i and wdata_i combinationally to t_addr_o, t_we_o, t_be_o and t_wdata_o.
REQ-011 SHALL drive t_req_o[k] = req_i & sel[k] & ~stall, combinationally, with zero added latency; gnt_o SHALL equal t_gnt_i of the selected target.
REQ-012 SHALL keep registers cur_tgt (target of outstanding transfers) and cnt (width $clog2(MAX_OUTSTANDING+1)).
REQ-013 SHALL assert stall when cnt == MAX_OUTSTANDING, or when cnt != 0 and the decoded target != cur_tgt; this guarantees in-order responses.
REQ-014 SHALL, on each accepted request (req_i & gnt_o), load cur_tgt with the decoded target.
REQ-015 SHALL update cnt per cycle as follows: +1 on grant only; -1 on rvalid_o only; unchanged on both or neither.
REQ-016 SHALL drive rvalid_o, rdata_o and err_o from t_rvalid_i[cur_tgt], t_rdata_i slice cur_tgt and t_err_i[cur_tgt]; rdata_o = 0 when rvalid_o = 0.
REQ-017 SHALL ignore t_rvalid_i from any target != cur_tgt, and any rvalid while cnt == 0 (no cnt change, no rvalid_o).
REQ-018 SHALL never let cnt wrap: no grant at MAX_OUTSTANDING; no decrement at 0.
REQ-019 SHALL, while req_i is low, drive all t_req_o low and gnt_o low.

Reset
REQ-020 SHALL, with rst_n low, hold cnt=0, cur_tgt=0, decode-error pending=0, rvalid_o=0, err_o=0 and rdata_o=0.
REQ-021 SHALL discard transfers outstanding at reset assertion; late target rvalids after reset SHALL be ignored per REQ-017.
REQ-022 SHALL accept a new request in the first cycle after rst_n deasserts.

Configuration
REQ-023 SHALL use macro ZR_BUS_DEMUX_DECERR_EN to compile in the decode-error responder.
REQ-024 SHALL, with ZR_BUS_DEMUX_DECERR_EN defined, treat unmapped as pseudo-target N_TARGETS, subject to REQ-013 stalls. A request to it gets gnt_o in the same cycle, then one cycle later rvalid_o=1, err_o=1 and rdata_o=0.
REQ-025 SHALL, with ZR_BUS_DEMUX_DECERR_EN undefined, never grant an unmapped request: gnt_o=0 and all t_req_o=0 until req_i drops or addr_i changes.

Verification
REQ-026 SHALL cover back-to-back reads: read 0x8000_0010 then 0x8000_0014, target 0 grants each cycle and rvalids 1 cycle later -> two gnt_o, two rvalid_o with matching rdata_o, cnt peaks at 1.
REQ-027 SHALL cover the outstanding limit: MAX_OUTSTANDING=2, target 0 withholds rvalid -> third request stalls (t_req_o=0, gnt_o=0) until the first rvalid, then is granted that same cycle.
REQ-028 SHALL cover target switching: grant to 0x8000_0000 (cnt=1), then request to 0x0000_4000 -> t_req_o[2]=0 until target 0 rvalid, then t_req_o[2]=1.
REQ-029 SHALL cover the decode error: read 0x2000_0000 with DECERR_EN -> gnt_o=1 in cycle 0; rvalid_o=1, err_o=1, rdata_o=0 in cycle 1. Without DECERR_EN -> gnt_o stays 0 for 10 cycles.
REQ-030 SHALL cover simultaneous events and reset: grant plus rvalid in the same cycle -> cnt unchanged. rst_n pulsed low with cnt=2 -> cnt=0, and a stray target rvalid afterwards produces no rvalid_o.
